output_writer: RTL and testbench

OUTPUT_WRITER -- requirements
Module: output_writer

---
 rtl/output_writer_pkg.sv | 21 ++
 rtl/output_writer_if.sv | 31 +++
 rtl/output_row_packer.sv | 49 ++++
 rtl/output_writer.sv | 127 ++++++++++++
 tb/tb_output_writer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/output_writer_pkg.sv
// Shared types and constants for the output SRAM row writer.
// The MARKER state only exists when OUTPUT_WRITER_END_MARKER_EN is defined.
package output_writer_pkg;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 16;
    localparam int ROW_BITS = 16;
    localparam int CNT_W    = 5;

    localparam logic [DATA_W-1:0] END_MARKER = 16'h00FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_WRITE
`ifdef OUTPUT_WRITER_END_MARKER_EN
        , ST_MARKER
`endif
    } wr_state_t;

endpackage

// File: rtl/output_writer_if.sv
// Control strobes in, SRAM write port and status out, for output_writer.
interface output_writer_if;
    import output_writer_pkg::*;

    logic              addr_clear;
    logic              bit_valid;
    logic              bit_data;
    logic              str_temp_to_write;
    logic              rst_output_row_temp;
    logic              frame_done;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              dut_sram_write_enable;
    logic              wr_busy;
    logic              proto_err;

    modport master (
        output addr_clear, bit_valid, bit_data, str_temp_to_write,
               rst_output_row_temp, frame_done,
        input  dut_sram_write_address, dut_sram_write_data,
               dut_sram_write_enable, wr_busy, proto_err
    );

    modport slave (
        input  addr_clear, bit_valid, bit_data, str_temp_to_write,
               rst_output_row_temp, frame_done,
        output dut_sram_write_address, dut_sram_write_data,
               dut_sram_write_enable, wr_busy, proto_err
    );

endinterface

// File: rtl/output_row_packer.sv
// Shifts result bits into a 16-bit row word; flags bits offered to a full row.
module output_row_packer
    import output_writer_pkg::*;
(
    input  logic                clk,
    input  logic                reset_b,
    input  logic                clr,
    input  logic                restart,
    input  logic                push,
    input  logic                bit_data,
    output logic [ROW_BITS-1:0] row_next,
    output logic                overflow
);

    logic [ROW_BITS-1:0] row_reg;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    // clr beats restart beats push; restart seeds a fresh row with one bit
    always_comb begin
        row_next = row_reg;
        cnt_next = cnt_reg;
        overflow = 1'b0;
        if (clr) begin
            row_next = '0;
            cnt_next = '0;
        end else if (restart) begin
            row_next = {{(ROW_BITS-1){1'b0}}, bit_data};
            cnt_next = CNT_W'(1);
        end else if (push) begin
            if (cnt_reg < CNT_W'(ROW_BITS)) begin
                row_next = {row_reg[ROW_BITS-2:0], bit_data};
                cnt_next = cnt_reg + 1'b1;
            end else begin
                overflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            row_reg <= '0;
            cnt_reg <= '0;
        end else begin
            row_reg <= row_next;
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/output_writer.sv
// Row-word writer: FSM plus address counter driving the output SRAM port.
// Define OUTPUT_WRITER_END_MARKER_EN to append a 16'h00FF word at frame end.
module output_writer
    import output_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_b,
    output_writer_if.slave    bus
);

`ifdef OUTPUT_WRITER_END_MARKER_EN
    localparam wr_state_t FRAME_END_STATE = ST_MARKER;
`else
    localparam wr_state_t FRAME_END_STATE = ST_IDLE;
`endif

    wr_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              pend_reg, pend_next;
    logic              err_reg, err_next, err_set;
    logic              we_reg, we_next;
    logic              pk_clr, pk_restart, pk_push, pk_ovf;
    logic [ROW_BITS-1:0] row_next;

    output_row_packer u_packer (
        .clk      (clk),
        .reset_b  (reset_b),
        .clr      (pk_clr),
        .restart  (pk_restart),
        .push     (pk_push),
        .bit_data (bus.bit_data),
        .row_next (row_next),
        .overflow (pk_ovf)
    );

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        pend_next  = pend_reg;
        err_set    = 1'b0;
        pk_clr     = 1'b0;
        pk_restart = 1'b0;
        pk_push    = 1'b0;
        case (state_reg)
            ST_IDLE: ;
            ST_ACCUM: begin
                if (bus.rst_output_row_temp) pk_clr = 1'b1;
                else if (bus.bit_valid)      pk_push = 1'b1;
                if (bus.str_temp_to_write) begin
                    state_next = ST_WRITE;
                    pend_next  = bus.frame_done;
                end else if (bus.frame_done) begin
                    state_next = FRAME_END_STATE;
                end
            end
            ST_WRITE: begin
                addr_next = addr_reg + 1'b1;
                // a bit arriving now is the first bit of the following row
                if (bus.bit_valid) pk_restart = 1'b1;
                else               pk_clr     = 1'b1;
                if (bus.str_temp_to_write) err_set = 1'b1;
                state_next = (pend_reg || bus.frame_done) ? FRAME_END_STATE : ST_ACCUM;
                pend_next  = 1'b0;
            end
`ifdef OUTPUT_WRITER_END_MARKER_EN
            ST_MARKER: begin
                addr_next  = addr_reg + 1'b1;
                state_next = ST_IDLE;
                if (bus.str_temp_to_write) err_set = 1'b1;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
        // run restart overrides everything else in every state
        if (bus.addr_clear) begin
            state_next = ST_ACCUM;
            addr_next  = '0;
            pend_next  = 1'b0;
            pk_clr     = 1'b1;
            pk_restart = 1'b0;
            pk_push    = 1'b0;
        end
    end

    assign err_next = err_reg | err_set | pk_ovf;

    always_comb begin
        we_next   = 1'b0;
        data_next = '0;
        if (state_next == ST_WRITE) begin
            we_next   = 1'b1;
            data_next = row_next;
        end
`ifdef OUTPUT_WRITER_END_MARKER_EN
        else if (state_next == ST_MARKER) begin
            we_next   = 1'b1;
            data_next = END_MARKER;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            pend_reg  <= 1'b0;
            err_reg   <= 1'b0;
            we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            pend_reg  <= pend_next;
            err_reg   <= err_next;
            we_reg    <= we_next;
        end
    end

    assign bus.dut_sram_write_address = addr_reg;
    assign bus.dut_sram_write_data    = data_reg;
    assign bus.dut_sram_write_enable  = we_reg;
    assign bus.wr_busy                = we_reg;
    assign bus.proto_err              = err_reg;

endmodule

// File: tb/tb_output_writer.sv
// Self-checking bench for output_writer: directed scenarios plus random rows
// checked against a row-level model of expected SRAM writes.
module tb_output_writer;
    import output_writer_pkg::*;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    output_writer_if bus();

    output_writer dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_err = 0;
    logic [27:0] got_q[$];
    logic [27:0] exp_q[$];
    int m_addr = 0;
    bit m_err = 1'b0;
    bit quiet = 1'b0;
    logic prev_we = 1'b0;
    logic [11:0] prev_addr = '0;
    int same_addr_viol = 0;

    always @(negedge clk) begin
        if (bus.dut_sram_write_enable === 1'b1) begin
            got_q.push_back({bus.dut_sram_write_address, bus.dut_sram_write_data});
            if (prev_we === 1'b1 && prev_addr === bus.dut_sram_write_address)
                same_addr_viol++;
            if (!quiet)
                $display("write addr=%03h data=%04h", bus.dut_sram_write_address,
                         bus.dut_sram_write_data);
        end
        prev_we   = bus.dut_sram_write_enable;
        prev_addr = bus.dut_sram_write_address;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.addr_clear          = 1'b0;
        bus.bit_valid           = 1'b0;
        bus.bit_data            = 1'b0;
        bus.str_temp_to_write   = 1'b0;
        bus.rst_output_row_temp = 1'b0;
        bus.frame_done          = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_b = 1'b0;
        step();
        reset_b = 1'b1;
        m_addr = 0;
        m_err = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic start_run();
        bus.addr_clear = 1'b1;
        step();
        idle_inputs();
        m_addr = 0;
    endtask

    // Expected word: first min(n,16) bits, first bit most significant.
    function automatic logic [15:0] row_word(input logic [31:0] bits, input int n);
        int k = (n > 16) ? 16 : n;
        int w = 0;
        for (int i = 0; i < k; i++)
            w = w + (int'(bits[i]) << (k - 1 - i));
        return 16'(w);
    endfunction

    task automatic run_row(input int n, input logic [31:0] bits, input bit same, input bit fd);
        bit s = same && (n >= 2);
        for (int i = 0; i < n; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_data  = bits[i];
            if (i == n - 1 && s) begin
                bus.str_temp_to_write = 1'b1;
                bus.frame_done        = fd;
            end
            step();
            idle_inputs();
        end
        if (!s) begin
            bus.str_temp_to_write = 1'b1;
            bus.frame_done        = fd;
            step();
            idle_inputs();
        end
        exp_q.push_back({m_addr[11:0], row_word(bits, n)});
        m_addr = (m_addr + 1) % 4096;
        if (n > 16) m_err = 1'b1;
`ifdef OUTPUT_WRITER_END_MARKER_EN
        if (fd) begin
            exp_q.push_back({m_addr[11:0], 16'h00FF});
            m_addr = (m_addr + 1) % 4096;
        end
`endif
    endtask

    task automatic check_writes(input string tag);
        int n;
        step(); step(); step();
        chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, got_q[i][27:16], exp_q[i][27:16]);
            chk({tag, "_data"}, got_q[i][15:0], exp_q[i][15:0]);
        end
        chk({tag, "_proto_err"}, bus.proto_err, m_err);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle(input string tag);
        bus.bit_valid = 1'b1;
        bus.bit_data = 1'b1;
        bus.str_temp_to_write = 1'b1;
        step();
        idle_inputs();
        step();
        chk({tag, "_idle_we"}, bus.dut_sram_write_enable, 1'b0);
        chk({tag, "_idle_busy"}, bus.wr_busy, 1'b0);
    endtask

    initial begin
        logic [31:0] b;
        int n;
        bit same;
        idle_inputs();
        bus.bit_valid = 1'b1;
        bus.str_temp_to_write = 1'b1;
        step();
        step();
        chk("rst_addr", bus.dut_sram_write_address, 12'h000);
        chk("rst_data", bus.dut_sram_write_data, 16'h0000);
        chk("rst_we", bus.dut_sram_write_enable, 1'b0);
        chk("rst_busy", bus.wr_busy, 1'b0);
        chk("rst_err", bus.proto_err, 1'b0);
        do_reset();

        // alternating 1/0 row, strobe on its own; write one cycle after strobe
        start_run();
        for (int i = 0; i < 16; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_data = ((i % 2) == 0);
            step();
            idle_inputs();
        end
        chk("alt_we_before", bus.dut_sram_write_enable, 1'b0);
        bus.str_temp_to_write = 1'b1;
        step();
        idle_inputs();
        chk("alt_we", bus.dut_sram_write_enable, 1'b1);
        chk("alt_busy", bus.wr_busy, 1'b1);
        chk("alt_addr", bus.dut_sram_write_address, 12'h000);
        chk("alt_data", bus.dut_sram_write_data, 16'hAAAA);
        step();
        chk("alt_we_after", bus.dut_sram_write_enable, 1'b0);
        exp_q.push_back({12'h000, 16'hAAAA});
        m_addr = 1;
        check_writes("alt");

        // 15th bit with the strobe, next row begins during WRITE
        do_reset();
        start_run();
        run_row(15, 32'h0000_7FFF, 1'b1, 1'b0);
        run_row(16, 32'h0000_0001, 1'b0, 1'b0);
        check_writes("samecyc");

        // overflow: 17 bits before strobe
        do_reset();
        start_run();
        b = $urandom;
        run_row(17, b, 1'b0, 1'b0);
        check_writes("ovf");

        // row clear wins over a simultaneous bit
        do_reset();
        start_run();
        for (int i = 0; i < 5; i++) begin
            bus.bit_valid = 1'b1;
            bus.bit_data = 1'b1;
            step();
            idle_inputs();
        end
        bus.rst_output_row_temp = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_data = 1'b1;
        step();
        idle_inputs();
        run_row(3, 32'h0000_0006, 1'b1, 1'b0);
        check_writes("rowclr");

        // frame_done with the strobe on row 3
        do_reset();
        start_run();
        run_row(4, $urandom, 1'b0, 1'b0);
        run_row(5, $urandom, 1'b1, 1'b0);
        run_row(4, $urandom, 1'b1, 1'b1);
        check_writes("frame");
        check_idle("frame");
        check_writes("frame_after");

        // frame_done alone in ACCUM
        start_run();
        run_row(3, $urandom, 1'b1, 1'b0);
        step();
        bus.frame_done = 1'b1;
        step();
        idle_inputs();
`ifdef OUTPUT_WRITER_END_MARKER_EN
        exp_q.push_back({m_addr[11:0], 16'h00FF});
        m_addr = (m_addr + 1) % 4096;
`endif
        check_writes("fdonly");
        check_idle("fdonly");
        check_writes("fdonly_after");

        // address wrap
        do_reset();
        start_run();
        quiet = 1'b1;
        for (int r = 0; r < 4095; r++) run_row(1, $urandom, 1'b0, 1'b0);
        quiet = 1'b0;
        run_row(2, $urandom, 1'b1, 1'b0);
        run_row(2, $urandom, 1'b1, 1'b0);
        check_writes("wrap");

        // reset during the WRITE cycle
        start_run();
        run_row(3, $urandom, 1'b1, 1'b0);
        chk("midrst_we_pre", bus.dut_sram_write_enable, 1'b1);
        reset_b = 1'b0;
        step();
        chk("midrst_we", bus.dut_sram_write_enable, 1'b0);
        chk("midrst_addr", bus.dut_sram_write_address, 12'h000);
        chk("midrst_data", bus.dut_sram_write_data, 16'h0000);
        chk("midrst_busy", bus.wr_busy, 1'b0);
        reset_b = 1'b1;
        m_err = 1'b0;
        check_idle("midrst");
        check_writes("midrst");

        // random rows, optional gaps, last row ends the frame
        do_reset();
        start_run();
        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(18, 1);
            b = $urandom;
            same = 1'($urandom_range(1, 0));
            run_row(n, b, same, r == 29);
            if ($urandom_range(1, 0) == 1) step();
        end
        check_writes("rand");

        chk("we_same_addr", same_addr_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
